// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state instruction sequencer driving an external combinational ALU.
// It holds a register file of eight 16-bit registers. Each accepted instruction runs
// IDLE -> DECODE -> (EXEC) -> WB -> IDLE.
//
// Ports:
//   clk, resetn       clock and asynchronous active-low reset
//   instr, instrValid instruction word {opcode[15:13], rx[12:10], ry[9:7]}, imm is instr[7:0]
//   instrReady        high only in IDLE and only while resetn is high
//   aluSel/aluA/aluB  registered ALU operation and operands, captured in DECODE
//   aluResult         combinational ALU result, sampled only in EXEC
//   rdAddr/rdData     asynchronous debug read of the register file
//   done, divErr      single-cycle retirement pulse; divErr marks a divide by zero
//   wbData            last value written back to the register file
module alu_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] instr,
  input  logic        instrValid,
  output logic        instrReady,
  output logic [2:0]  aluSel,
  output logic [15:0] aluA,
  output logic [15:0] aluB,
  input  logic [15:0] aluResult,
  input  logic [2:0]  rdAddr,
  output logic [15:0] rdData,
  output logic        done,
  output logic        divErr,
  output logic [15:0] wbData
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;
  localparam logic [1:0] StWb     = 2'd3;

  localparam logic [2:0] OpDiv = 3'b100;
  localparam logic [2:0] OpLdi = 3'b110;
  localparam logic [2:0] OpNop = 3'b111;

  logic [1:0]  state_q, state_d;
  logic [15:0] instr_q;
  logic [15:0] regs_q [8];
  logic [2:0]  alu_sel_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [15:0] result_q;
  logic        wr_en_q;
  logic        div_err_q;
  logic [15:0] wb_data_q;

  logic [2:0]  opcode;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [7:0]  imm;
  logic [15:0] rx_val;
  logic [15:0] ry_val;
  logic        skip_exec;

  // imm overlaps ry[0]; the opcode decides which interpretation applies.
  assign opcode = instr_q[15:13];
  assign rx     = instr_q[12:10];
  assign ry     = instr_q[9:7];
  assign imm    = instr_q[7:0];
  assign rx_val = regs_q[rx];
  assign ry_val = regs_q[ry];

  // LDI, NOP and divide-by-zero never touch the ALU.
  assign skip_exec = (opcode == OpLdi) || (opcode == OpNop) ||
                     ((opcode == OpDiv) && (ry_val == 16'h0000));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (instrValid) state_d = StDecode;
      StDecode: state_d = skip_exec ? StWb : StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      alu_sel_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      result_q  <= '0;
      wr_en_q   <= 1'b0;
      div_err_q <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (instrValid) instr_q <= instr;
        end
        StDecode: begin
          alu_sel_q <= opcode;
          alu_a_q   <= rx_val;
          alu_b_q   <= ry_val;
          // Preload the LDI value; ALU ops overwrite it in EXEC.
          result_q  <= {8'h00, imm};
          wr_en_q   <= 1'b1;
          div_err_q <= 1'b0;
          if (opcode == OpNop) begin
            wr_en_q <= 1'b0;
          end else if ((opcode == OpDiv) && (ry_val == 16'h0000)) begin
            wr_en_q   <= 1'b0;
            div_err_q <= 1'b1;
          end
        end
        StExec: begin
          result_q <= aluResult;
        end
        StWb: begin
          // Written at the end of WB, so rdData shows the old value during WB.
          if (wr_en_q) begin
            regs_q[rx] <= result_q;
            wb_data_q  <= result_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign instrReady = resetn && (state_q == StIdle);
  assign done       = (state_q == StWb);
  assign divErr     = (state_q == StWb) && div_err_q;
  assign aluSel     = alu_sel_q;
  assign aluA       = alu_a_q;
  assign aluB       = alu_b_q;
  assign rdData     = regs_q[rdAddr];
  assign wbData     = wb_data_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer.
// It includes a behavioural ALU for the aluResult input. A register-file model applies
// each instruction's arithmetic directly and predicts latency, pulses and final state.
module tb_alu_sequencer;

  logic        clk;
  logic        resetn;
  logic [15:0] instr;
  logic        instrValid;
  logic        instrReady;
  logic [2:0]  aluSel;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic [15:0] aluResult;
  logic [2:0]  rdAddr;
  logic [15:0] rdData;
  logic        done;
  logic        divErr;
  logic [15:0] wbData;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model [8];
  logic [15:0] wb_exp;

  alu_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .instr      (instr),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .aluSel     (aluSel),
    .aluA       (aluA),
    .aluB       (aluB),
    .aluResult  (aluResult),
    .rdAddr     (rdAddr),
    .rdData     (rdData),
    .done       (done),
    .divErr     (divErr),
    .wbData     (wbData)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Downstream combinational ALU.
  always_comb begin
    aluResult = 16'h0000;
    case (aluSel)
      3'd0: aluResult = aluA + aluB;
      3'd1: aluResult = aluA ^ aluB;
      3'd2: aluResult = aluA - aluB;
      3'd3: aluResult = aluA * aluB;
      3'd4: aluResult = (aluB == 16'h0000) ? 16'h0000 : aluA / aluB;
      3'd5: aluResult = 16'($countones(aluB));
      default: aluResult = 16'h0000;
    endcase
  end

  function automatic logic [15:0] enc_ldi(input logic [2:0] rx, input logic [7:0] imm);
    return {3'b110, rx, 2'b00, imm};
  endfunction

  function automatic logic [15:0] enc_op(input logic [2:0] op, input logic [2:0] rx,
                                         input logic [2:0] ry);
    return {op, rx, ry, 7'b0000000};
  endfunction

  // Issue one instruction and check latency, pulses, operands and final state.
  task automatic issue(input logic [15:0] ins);
    logic [2:0]  op, rx, ry;
    logic [15:0] a, b, exp_val;
    bit          wr, derr;
    int          exp_n, n;
    op = ins[15:13];
    rx = ins[12:10];
    ry = ins[9:7];
    a = model[rx];
    b = model[ry];
    wr = 1'b1;
    derr = 1'b0;
    exp_n = 2;
    exp_val = 16'h0000;
    case (op)
      3'd0: exp_val = a + b;
      3'd1: exp_val = a ^ b;
      3'd2: exp_val = a - b;
      3'd3: exp_val = a * b;
      3'd4: begin
        if (b == 16'h0000) begin
          wr = 1'b0; derr = 1'b1; exp_n = 1;
        end else begin
          exp_val = a / b;
        end
      end
      3'd5: exp_val = 16'($countones(b));
      3'd6: begin exp_val = {8'h00, ins[7:0]}; exp_n = 1; end
      default: begin wr = 1'b0; exp_n = 1; end
    endcase

    @(negedge clk);
    vectors++;
    if (instrReady !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_idle: got %b expected 1", instrReady);
    end
    instr = ins;
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    vectors++;
    if (instrReady !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_decode: got %b expected 0", instrReady);
    end

    n = 0;
    while (done !== 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n != exp_n) begin
      miscompares++;
      $display("FAIL latency op=%0d: got %0d edges expected %0d", op, n, exp_n);
    end
    if (done === 1'b1) begin
      vectors++;
      if (divErr !== derr) begin
        miscompares++;
        $display("FAIL div_err op=%0d: got %b expected %b", op, divErr, derr);
      end
      rdAddr = rx;
      #1;
      vectors++;
      if (rdData !== a) begin
        miscompares++;
        $display("FAIL pre_write_read R%0d: got %h expected %h", rx, rdData, a);
      end
      vectors++;
      if (aluSel !== op || aluA !== a || aluB !== b) begin
        miscompares++;
        $display("FAIL alu_operands: got sel=%0d a=%h b=%h expected sel=%0d a=%h b=%h",
                 aluSel, aluA, aluB, op, a, b);
      end
    end

    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || divErr !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: got done=%b divErr=%b expected 0 0", done, divErr);
    end
    if (wr) begin
      model[rx] = exp_val;
      wb_exp = exp_val;
    end
    vectors++;
    if (wbData !== wb_exp) begin
      miscompares++;
      $display("FAIL wb_data op=%0d: got %h expected %h", op, wbData, wb_exp);
    end
    for (int r = 0; r < 8; r++) begin
      rdAddr = 3'(r);
      #1;
      vectors++;
      if (rdData !== model[r]) begin
        miscompares++;
        $display("FAIL reg R%0d after op=%0d: got %h expected %h", r, op, rdData, model[r]);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    instrValid = 1'b0;
    instr = 16'h0000;
    rdAddr = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (instrReady !== 1'b0 || done !== 1'b0 || divErr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready=%b done=%b divErr=%b expected 0 0 0",
               instrReady, done, divErr);
    end
    vectors++;
    if (aluSel !== 3'd0 || aluA !== 16'h0 || aluB !== 16'h0 || wbData !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_data: got sel=%0d a=%h b=%h wb=%h expected all 0",
               aluSel, aluA, aluB, wbData);
    end
    for (int r = 0; r < 8; r++) begin
      rdAddr = 3'(r);
      #1;
      vectors++;
      if (rdData !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_reg R%0d: got %h expected 0000", r, rdData);
      end
    end
    for (int r = 0; r < 8; r++) model[r] = 16'h0000;
    wb_exp = 16'h0000;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (instrReady !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b expected 1", instrReady);
    end
  endtask

  task automatic test_add();
    issue(enc_ldi(3'd1, 8'h05));
    issue(enc_ldi(3'd2, 8'h03));
    issue(enc_op(3'd0, 3'd1, 3'd2));
    rdAddr = 3'd1;
    #1;
    vectors++;
    if (rdData !== 16'h0008 || wbData !== 16'h0008) begin
      miscompares++;
      $display("FAIL add_scenario: got R1=%h wb=%h expected 0008 0008", rdData, wbData);
    end
  endtask

  task automatic test_div_zero();
    issue(enc_ldi(3'd3, 8'h07));
    issue(enc_ldi(3'd4, 8'h00));
    issue(enc_op(3'd4, 3'd3, 3'd4));
    rdAddr = 3'd3;
    #1;
    vectors++;
    if (rdData !== 16'h0007) begin
      miscompares++;
      $display("FAIL div_zero_keep: got R3=%h expected 0007", rdData);
    end
  endtask

  task automatic test_mul_wrap();
    issue(enc_ldi(3'd5, 8'hFF));
    issue(enc_op(3'd3, 3'd5, 3'd5));
    rdAddr = 3'd5;
    #1;
    vectors++;
    if (rdData !== 16'hFE01) begin
      miscompares++;
      $display("FAIL mul_square: got R5=%h expected fe01", rdData);
    end
    issue(enc_op(3'd2, 3'd0, 3'd5));
    rdAddr = 3'd0;
    #1;
    vectors++;
    if (rdData !== 16'h01FF) begin
      miscompares++;
      $display("FAIL sub_wrap: got R0=%h expected 01ff", rdData);
    end
  endtask

  task automatic test_popcount();
    issue(enc_ldi(3'd6, 8'hB5));
    issue(enc_op(3'd5, 3'd7, 3'd6));
    rdAddr = 3'd7;
    #1;
    vectors++;
    if (rdData !== 16'h0005) begin
      miscompares++;
      $display("FAIL popcount: got R7=%h expected 0005", rdData);
    end
  endtask

  task automatic test_same_reg();
    issue(enc_ldi(3'd2, 8'h9C));
    issue(enc_op(3'd2, 3'd2, 3'd2));
    rdAddr = 3'd2;
    #1;
    vectors++;
    if (rdData !== 16'h0000) begin
      miscompares++;
      $display("FAIL sub_self: got R2=%h expected 0000", rdData);
    end
  endtask

  task automatic test_back_to_back();
    int dones, readies;
    logic [15:0] exp_r1;
    issue(enc_ldi(3'd1, 8'($urandom_range(0, 255))));
    issue(enc_ldi(3'd2, 8'($urandom_range(1, 255))));
    dones = 0;
    readies = 0;
    @(negedge clk);
    instr = enc_op(3'd0, 3'd1, 3'd2);
    instrValid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
      if (instrReady === 1'b1) readies++;
    end
    instrValid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    exp_r1 = model[1] + 16'(3 * model[2]);
    model[1] = exp_r1;
    wb_exp = exp_r1;
    vectors++;
    if (dones != 3) begin
      miscompares++;
      $display("FAIL b2b_dones: got %0d expected 3", dones);
    end
    vectors++;
    if (readies != 3) begin
      miscompares++;
      $display("FAIL b2b_ready_cycles: got %0d expected 3", readies);
    end
    rdAddr = 3'd1;
    #1;
    vectors++;
    if (rdData !== exp_r1 || wbData !== exp_r1) begin
      miscompares++;
      $display("FAIL b2b_result: got R1=%h wb=%h expected %h", rdData, wbData, exp_r1);
    end
  endtask

  task automatic test_mid_reset();
    int stray;
    issue(enc_ldi(3'd1, 8'h05));
    issue(enc_ldi(3'd2, 8'h03));
    @(negedge clk);
    instr = enc_op(3'd0, 3'd1, 3'd2);
    instrValid = 1'b1;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b0 || instrReady !== 1'b0 || aluA !== 16'h0 || aluB !== 16'h0 ||
        aluSel !== 3'd0 || wbData !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got done=%b ready=%b a=%h b=%h sel=%0d wb=%h",
               done, instrReady, aluA, aluB, aluSel, wbData);
    end
    for (int r = 0; r < 8; r++) model[r] = 16'h0000;
    wb_exp = 16'h0000;
    for (int r = 0; r < 8; r++) begin
      rdAddr = 3'(r);
      #1;
      vectors++;
      if (rdData !== 16'h0000) begin
        miscompares++;
        $display("FAIL mid_reset_reg R%0d: got %h expected 0000", r, rdData);
      end
    end
    stray = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) stray++;
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (stray != 0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_done: got %0d pulses expected 0", stray);
    end
    vectors++;
    if (instrReady !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_ready: got %b expected 1", instrReady);
    end
    issue(enc_ldi(3'd3, 8'h42));
    issue(enc_op(3'd0, 3'd3, 3'd3));
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) op = 3'd6;
      if (op == 3'd6) begin
        issue(enc_ldi(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))));
      end else begin
        issue(enc_op(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_div_zero();
    test_mul_wrap();
    test_popcount();
    test_same_reg();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
